// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between the core and
// the memory bus. Does byte-lane steering, byte enables, load extension and
// alignment checking, and holds the bus strobes across wait states.
// Optional feature macro: MEM_TIMEOUT_EN (bus wait timeout, fault code 10).
module mem_access_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iReq,
    input  logic                iWrite,
    input  logic [1:0]          iSize,
    input  logic                iSigned,
    input  logic [ADDR_W-1:0]   iAddr,
    input  logic [DATA_W-1:0]   iWData,
    output logic                oBusy,
    output logic                oDone,
    output logic [DATA_W-1:0]   oRData,
    output logic [1:0]          oFault,
    output logic [ADDR_W-1:0]   oMemAddr,
    output logic [DATA_W-1:0]   oMemData,
    output logic [DATA_W/8-1:0] oMemBE,
    output logic                oMemRead,
    output logic                oMemWrite,
    input  logic [DATA_W-1:0]   iMemData,
    input  logic                iRdy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned SH_W  = $clog2(DATA_W) + 1;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
`ifdef MEM_TIMEOUT_EN
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

    // Reject illegal configurations at elaboration
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("mem_access_unit: DATA_W must be 32 or 64");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                write_q, write_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          fault_q, fault_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0]     wait_q, wait_d;
`endif

    logic [OFF_W-1:0]    req_off_c;
    logic                misalign_c;
    logic [BE_W-1:0]     req_be_c;
    logic [DATA_W-1:0]   size_mask_c;
    logic [DATA_W-1:0]   req_wdata_c;

    logic [DATA_W-1:0]        ld_shift_c;
    logic [SH_W-1:0]          ext_sh_c;
    logic [DATA_W-1:0]        ld_top_c;
    logic signed [DATA_W-1:0] ld_sext_c;
    logic [DATA_W-1:0]        load_c;

    // Decode the incoming request: lane offset, alignment, enables, steered data
    always_comb begin
        req_off_c   = iAddr[OFF_W-1:0];
        misalign_c  = 1'b0;
        req_be_c    = '0;
        size_mask_c = '0;
        case (iSize)
            2'b00: begin
                req_be_c    = BE_W'(1) << req_off_c;
                size_mask_c = DATA_W'(8'hFF);
            end
            2'b01: begin
                misalign_c  = req_off_c[0];
                req_be_c    = BE_W'(3) << req_off_c;
                size_mask_c = DATA_W'(16'hFFFF);
            end
            2'b10: begin
                misalign_c  = (req_off_c[1:0] != 2'b00);
                req_be_c    = BE_W'(4'hF) << req_off_c;
                size_mask_c = DATA_W'(32'hFFFF_FFFF);
            end
            default: begin
                // double only exists on a 64-bit bus
                misalign_c  = (DATA_W == 32) || (req_off_c != '0);
                req_be_c    = '1;
                size_mask_c = '1;
            end
        endcase
        req_wdata_c = (iWData & size_mask_c) << {req_off_c, 3'b000};
    end

    // Right-justify the selected bus lanes and extend to the full width
    always_comb begin
        ld_shift_c = iMemData >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ext_sh_c = SH_W'(DATA_W - 8);
            2'b01:   ext_sh_c = SH_W'(DATA_W - 16);
            2'b10:   ext_sh_c = SH_W'(DATA_W - 32);
            default: ext_sh_c = '0;
        endcase
        // park the access at the top, then shift back down with the desired fill
        ld_top_c  = ld_shift_c << ext_sh_c;
        ld_sext_c = ld_top_c;
        ld_sext_c = ld_sext_c >>> ext_sh_c;
        if (signed_q) begin
            load_c = ld_sext_c;
        end else begin
            load_c = ld_top_c >> ext_sh_c;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_be_d    = mem_be_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
`ifdef MEM_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iReq) begin
                    busy_d   = 1'b1;
                    off_d    = req_off_c;
                    size_d   = iSize;
                    signed_d = iSigned;
                    write_d  = iWrite;
                    if (misalign_c) begin
                        // fault straight away, the bus never sees it
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = FAULT_MISALIGN;
                    end else begin
                        state_d     = S_ACCESS;
                        fault_d     = FAULT_OK;
                        mem_addr_d  = {iAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_data_d  = req_wdata_c;
                        mem_be_d    = req_be_c;
                        mem_read_d  = ~iWrite;
                        mem_write_d = iWrite;
`ifdef MEM_TIMEOUT_EN
                        wait_d      = '0;
`endif
                    end
                end
            end
            S_ACCESS: begin
                if (iRdy) begin
                    // a ready on the last permitted cycle still completes cleanly
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    fault_d     = FAULT_OK;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (!write_q) begin
                        rdata_d = load_c;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    fault_d     = FAULT_TIMEOUT;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else begin
                    wait_d = wait_q + TO_W'(1);
`endif
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything including the strobes
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            off_q       <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_be_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_be_q    <= mem_be_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oRData    = rdata_q;
    assign oFault    = fault_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemData  = mem_data_q;
    assign oMemBE    = mem_be_q;
    assign oMemRead  = mem_read_q;
    assign oMemWrite = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit on a 32-bit bus.
// Defining MEM_TIMEOUT_EN for both files exercises the timeout path (TIMEOUT=8).
module tb_mem_access_unit;

    logic        iClk;
    logic        nRst;
    logic        iReq;
    logic        iWrite;
    logic [1:0]  iSize;
    logic        iSigned;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oRData;
    logic [1:0]  oFault;
    logic [31:0] oMemAddr;
    logic [31:0] oMemData;
    logic [3:0]  oMemBE;
    logic        oMemRead;
    logic        oMemWrite;
    logic [31:0] iMemData;
    logic        iRdy;

    int vec_cnt;
    int err_cnt;

    mem_access_unit #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(8)
    ) dut (
        .iClk     (iClk),
        .nRst     (nRst),
        .iReq     (iReq),
        .iWrite   (iWrite),
        .iSize    (iSize),
        .iSigned  (iSigned),
        .iAddr    (iAddr),
        .iWData   (iWData),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oRData   (oRData),
        .oFault   (oFault),
        .oMemAddr (oMemAddr),
        .oMemData (oMemData),
        .oMemBE   (oMemBE),
        .oMemRead (oMemRead),
        .oMemWrite(oMemWrite),
        .iMemData (iMemData),
        .iRdy     (iRdy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Present a request in IDLE for exactly one accept edge
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        iReq    = 1'b1;
        iWrite  = w;
        iSize   = sz;
        iSigned = sg;
        iAddr   = a;
        iWData  = wd;
        step();
        iReq    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] all_or;
        nRst = 1'b0;
        #3;
        all_or = oRData | oMemAddr | oMemData;
        vec_cnt++;
        if ({oBusy, oDone, oFault, oMemBE, oMemRead, oMemWrite} !== 10'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 0", {oBusy, oDone, oFault, oMemBE, oMemRead, oMemWrite});
        end
        vec_cnt++;
        if (all_or !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h expected 0", all_or);
        end
        step();
        nRst = 1'b1;
        step();
    endtask

    task automatic test_word_store();
        iRdy = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        vec_cnt++;
        if ({oMemRead, oMemWrite, oDone, oBusy} !== 4'b0101) begin
            err_cnt++;
            $display("FAIL wst_strobe: got %b expected 0101", {oMemRead, oMemWrite, oDone, oBusy});
        end
        vec_cnt++;
        if ({oMemAddr, oMemBE, oMemData} !== {32'h0000_0100, 4'b1111, 32'hDEAD_BEEF}) begin
            err_cnt++;
            $display("FAIL wst_bus: got %h/%b/%h expected 00000100/1111/deadbeef", oMemAddr, oMemBE, oMemData);
        end
        step();
        vec_cnt++;
        if ({oMemWrite, oDone, oBusy, oFault} !== 5'b01100) begin
            err_cnt++;
            $display("FAIL wst_done: got %b expected 01100", {oMemWrite, oDone, oBusy, oFault});
        end
        step();
        vec_cnt++;
        if ({oDone, oBusy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL wst_idle: got %b expected 00", {oDone, oBusy});
        end
    endtask

    task automatic test_loads();
        iRdy     = 1'b1;
        iMemData = 32'h8012_3456;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        vec_cnt++;
        if ({oMemRead, oMemWrite, oMemBE, oMemAddr} !== {1'b1, 1'b0, 4'b1000, 32'h0000_0100}) begin
            err_cnt++;
            $display("FAIL lb_bus: got %b%b/%b/%h expected 10/1000/00000100", oMemRead, oMemWrite, oMemBE, oMemAddr);
        end
        step();
        vec_cnt++;
        if ({oDone, oFault, oRData} !== {1'b1, 2'b00, 32'hFFFF_FF80}) begin
            err_cnt++;
            $display("FAIL lb_signed: got %b/%b/%h expected 1/00/ffffff80", oDone, oFault, oRData);
        end
        step();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        step();
        vec_cnt++;
        if ({oDone, oRData} !== {1'b1, 32'h0000_0080}) begin
            err_cnt++;
            $display("FAIL lb_unsigned: got %b/%h expected 1/00000080", oDone, oRData);
        end
        step();
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
        vec_cnt++;
        if (oMemBE !== 4'b1100) begin
            err_cnt++;
            $display("FAIL lh_be: got %b expected 1100", oMemBE);
        end
        step();
        vec_cnt++;
        if (oRData !== 32'hFFFF_8012) begin
            err_cnt++;
            $display("FAIL lh_signed: got %h expected ffff8012", oRData);
        end
        step();
        issue(1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0);
        step();
        vec_cnt++;
        if (oRData !== 32'h8012_3456) begin
            err_cnt++;
            $display("FAIL lw: got %h expected 80123456", oRData);
        end
        step();
    endtask

    task automatic test_store_steer_and_misalign();
        iRdy = 1'b1;
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD);
        vec_cnt++;
        if ({oMemAddr, oMemBE, oMemData} !== {32'h0000_0200, 4'b1100, 32'hABCD_0000}) begin
            err_cnt++;
            $display("FAIL sh_bus: got %h/%b/%h expected 00000200/1100/abcd0000", oMemAddr, oMemBE, oMemData);
        end
        step();
        step();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'hFFFF_FF5A);
        vec_cnt++;
        if ({oMemBE, oMemData} !== {4'b0010, 32'h0000_5A00}) begin
            err_cnt++;
            $display("FAIL sb_bus: got %b/%h expected 0010/00005a00", oMemBE, oMemData);
        end
        step();
        step();
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0);
        vec_cnt++;
        if ({oDone, oBusy, oFault, oMemRead, oMemWrite} !== 6'b110100) begin
            err_cnt++;
            $display("FAIL lh_misalign: got %b expected 110100", {oDone, oBusy, oFault, oMemRead, oMemWrite});
        end
        step();
        vec_cnt++;
        if ({oDone, oBusy, oMemRead, oMemWrite} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL lh_misalign_after: got %b expected 0000", {oDone, oBusy, oMemRead, oMemWrite});
        end
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_5678);
        vec_cnt++;
        if ({oDone, oFault, oMemWrite} !== 4'b1010) begin
            err_cnt++;
            $display("FAIL sw_misalign: got %b expected 1010", {oDone, oFault, oMemWrite});
        end
        step();
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        vec_cnt++;
        if ({oDone, oFault, oMemRead} !== 4'b1010) begin
            err_cnt++;
            $display("FAIL dbl_on_32: got %b expected 1010", {oDone, oFault, oMemRead});
        end
        step();
    endtask

    task automatic test_wait_states();
        iRdy     = 1'b0;
        iMemData = 32'h1122_3344;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            vec_cnt++;
            if ({oMemRead, oMemWrite, oDone, oBusy, oMemBE, oMemAddr} !== {4'b1001, 4'b1111, 32'h0000_0300}) begin
                err_cnt++;
                $display("FAIL wait_hold c%0d: got %b/%b/%h expected 1001/1111/00000300",
                         k, {oMemRead, oMemWrite, oDone, oBusy}, oMemBE, oMemAddr);
            end
            if (k == 2 || k == 4) begin
                iReq   = 1'b1;
                iWrite = 1'b1;
                iAddr  = 32'h0000_0400;
            end else begin
                iReq = 1'b0;
            end
            if (k == 6) iRdy = 1'b1;
            step();
        end
        iReq = 1'b0;
        vec_cnt++;
        if ({oDone, oFault, oRData} !== {1'b1, 2'b00, 32'h1122_3344}) begin
            err_cnt++;
            $display("FAIL wait_done: got %b/%b/%h expected 1/00/11223344", oDone, oFault, oRData);
        end
        step();
        step();
        vec_cnt++;
        if ({oBusy, oMemRead, oMemWrite} !== 3'b000) begin
            err_cnt++;
            $display("FAIL wait_no_queue: got %b expected 000", {oBusy, oMemRead, oMemWrite});
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        iRdy     = 1'b0;
        iMemData = 32'hCAFE_F00D;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            vec_cnt++;
            if ({oMemRead, oDone} !== 2'b10) begin
                err_cnt++;
                $display("FAIL to_hold c%0d: got %b expected 10", k, {oMemRead, oDone});
            end
            step();
        end
        vec_cnt++;
        if ({oDone, oFault, oMemRead, oRData} !== {1'b1, 2'b10, 1'b0, 32'h1122_3344}) begin
            err_cnt++;
            $display("FAIL to_fault: got %b/%b/%b/%h expected 1/10/0/11223344", oDone, oFault, oMemRead, oRData);
        end
        step();
        for (int k = 1; k <= 7; k++) step();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0504, 32'h0);
        for (int k = 1; k <= 7; k++) step();
        iRdy = 1'b1;
        step();
        vec_cnt++;
        if ({oDone, oFault, oRData} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
            err_cnt++;
            $display("FAIL to_race: got %b/%b/%h expected 1/00/cafef00d", oDone, oFault, oRData);
        end
        step();
    endtask
`else
    task automatic test_long_wait();
        iRdy     = 1'b0;
        iMemData = 32'hCAFE_F00D;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        for (int k = 1; k <= 300; k++) step();
        vec_cnt++;
        if ({oMemRead, oDone, oBusy} !== 3'b101) begin
            err_cnt++;
            $display("FAIL long_wait_hold: got %b expected 101", {oMemRead, oDone, oBusy});
        end
        iRdy = 1'b1;
        step();
        vec_cnt++;
        if ({oDone, oFault, oRData} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
            err_cnt++;
            $display("FAIL long_wait_done: got %b/%b/%h expected 1/00/cafef00d", oDone, oFault, oRData);
        end
        step();
    endtask
`endif

    task automatic test_reset_mid_access();
        iRdy = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0600, 32'h5555_AAAA);
        vec_cnt++;
        if (oMemWrite !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_mid_pre: got %b expected 1", oMemWrite);
        end
        #2;
        nRst = 1'b0;
        #1;
        vec_cnt++;
        if ({oBusy, oDone, oMemWrite, oMemRead, oMemBE, oFault} !== 10'b0 ||
            (oMemAddr | oMemData | oRData) !== 32'h0) begin
            err_cnt++;
            $display("FAIL rst_mid_clear: got %b/%h expected 0/0",
                     {oBusy, oDone, oMemWrite, oMemRead, oMemBE, oFault}, oMemAddr | oMemData | oRData);
        end
        iRdy = 1'b1;
        step();
        step();
        vec_cnt++;
        if (oDone !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_nodone: got %b expected 0", oDone);
        end
        nRst = 1'b1;
        step();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0640, 32'h0BAD_F00D);
        vec_cnt++;
        if ({oMemWrite, oMemAddr} !== {1'b1, 32'h0000_0640}) begin
            err_cnt++;
            $display("FAIL rst_mid_reaccept: got %b/%h expected 1/00000640", oMemWrite, oMemAddr);
        end
        step();
        vec_cnt++;
        if ({oDone, oFault} !== 3'b100) begin
            err_cnt++;
            $display("FAIL rst_mid_done: got %b expected 100", {oDone, oFault});
        end
        step();
    endtask

    task automatic test_back_to_back();
        iRdy = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0700, 32'h0000_0001);
        step();
        // request held high from the DONE cycle: ignored there, taken in IDLE
        iReq   = 1'b1;
        iWrite = 1'b1;
        iAddr  = 32'h0000_0704;
        iWData = 32'h0000_0002;
        step();
        vec_cnt++;
        if ({oBusy, oMemWrite} !== 2'b00) begin
            err_cnt++;
            $display("FAIL b2b_done_ignore: got %b expected 00", {oBusy, oMemWrite});
        end
        step();
        iReq = 1'b0;
        vec_cnt++;
        if ({oBusy, oMemWrite, oMemAddr, oMemData} !== {2'b11, 32'h0000_0704, 32'h0000_0002}) begin
            err_cnt++;
            $display("FAIL b2b_accept: got %b/%h/%h expected 11/00000704/00000002",
                     {oBusy, oMemWrite}, oMemAddr, oMemData);
        end
        step();
        vec_cnt++;
        if (oDone !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_done: got %b expected 1", oDone);
        end
        step();
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        nRst     = 1'b0;
        iReq     = 1'b0;
        iWrite   = 1'b0;
        iSize    = 2'b00;
        iSigned  = 1'b0;
        iAddr    = 32'h0;
        iWData   = 32'h0;
        iMemData = 32'h0;
        iRdy     = 1'b0;
        test_reset();
        test_word_store();
        test_loads();
        test_store_steer_and_misalign();
        test_wait_states();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory access unit placed between the processor control/datapath and the memory bus, replacing the bare MAR/MDR/MOR plus `iRdy` arrangement. It accepts one load or store at a time and performs byte-lane steering, byte-enable generation, sign/zero extension and alignment checking. It holds the bus strobes through an arbitrary number of wait states. The data width is parametrised.

## Interface
- `DATA_W`, 32: memory data width. Legal values are 32 and 64.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 255: number of wait cycles before a bus timeout fault. Used only when `MEM_TIMEOUT_EN` is defined.
- `iClk` in, 1: clock. All state changes on the rising edge.
- `nRst` in, 1: asynchronous, active-low reset.
- `iReq` in, 1: access request. Sampled only in IDLE.
- `iWrite` in, 1: 1 = store, 0 = load.
- `iSize` in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = double (legal only when `DATA_W`=64).
- `iSigned` in, 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `iAddr` in, `ADDR_W`: byte address.
- `iWData` in, `DATA_W`: store data, right-justified.
- `oBusy` out, 1: high from the cycle after acceptance up to and including the `oDone` cycle.
- `oDone` out, 1: one-cycle completion pulse.
- `oRData` out, `DATA_W`: load result, extended. Valid with `oDone` and held until the next acceptance.
- `oFault` out, 2: fault code, valid with `oDone`. 00 = ok, 01 = misaligned, 10 = timeout.
- `oMemAddr` out, `ADDR_W`: aligned bus address. The low log2(`DATA_W`/8) bits are zero.
- `oMemData` out, `DATA_W`: lane-steered store data.
- `oMemBE` out, `DATA_W`/8: byte enables.
- `oMemRead` out, 1: read strobe.
- `oMemWrite` out, 1: write strobe.
- `iMemData` in, `DATA_W`: read data from the bus.
- `iRdy` in, 1: bus completion. Sampled while a strobe is high.

## Operation
- States:
  - IDLE
  - ACCESS
  - DONE
- IDLE, on `iReq`=1:
  - Register address, size, signedness and direction.
  - Compute the byte offset `off` = `iAddr` mod (`DATA_W`/8).
- Misaligned request: half with `off`[0]≠0; word with `off`[1:0]≠0; double with `off`≠0; size 11 when `DATA_W`=32.
  - Go to DONE with `oFault`=01.
  - No strobe is ever raised.
- Aligned request: go to ACCESS.
- In ACCESS:
  - Exactly one of `oMemRead`/`oMemWrite` is high, with `oMemAddr`, `oMemBE` and `oMemData` stable.
  - On `iRdy`=1, capture and go to DONE with `oFault`=00.
- DONE:
  - `oDone`=1 for exactly one cycle, then IDLE.
  - `iReq` is ignored in ACCESS and DONE; it is not queued.
- Byte enables, little-endian:
  - byte = 1<<`off`
  - half = 3<<`off`
  - word = 0xF<<`off`
  - double = all ones
- Store data: `iWData` is shifted left by 8·`off`. Unused lanes are 0.
- Load data: the selected lanes of `iMemData` are shifted right by 8·`off`. Bits above the access size are filled with the top data bit when `iSigned`=1, otherwise 0. A word or double load fills the full width.

## Timing
- Reset: state IDLE. Every output is 0, including `oRData`, `oFault` and all strobes.
- Reset asserted mid-ACCESS drops the strobes immediately (asynchronous) and raises no `oDone`.
- Latency, measured from the accept edge to the `oDone` cycle:
  - Aligned access with `iRdy` already high in the first ACCESS cycle: 2 cycles.
  - Each extra cycle with `iRdy`=0 adds 1 cycle.
  - Misaligned access: 1 cycle.
- Throughput: minimum spacing between accepted requests is 3 cycles (IDLE, ACCESS, DONE).
- `iRdy` outside ACCESS is ignored.
- Strobes deassert in the DONE cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with `iRdy`=0.
  - When it reaches `TIMEOUT`, the unit drops the strobes and goes to DONE with `oFault`=10 and `oRData` unchanged.
  - `iRdy` arriving in the same cycle the count reaches `TIMEOUT` wins: `oFault`=00.
- `MEM_TIMEOUT_EN` undefined: no counter, and ACCESS waits indefinitely. Fault code 10 is never produced.

## Test plan
- Word store at 0x100, data 0xDEADBEEF, `iRdy` high immediately -> `oMemAddr`=0x100, `oMemBE`=1111, `oMemWrite` for 1 cycle, `oDone` 2 cycles after accept, `oFault`=00.
- Signed byte load at 0x103, `iMemData`=0x80123456 -> `oMemBE`=1000, `oRData`=0xFFFFFF80. Repeat with `iSigned`=0 -> 0x00000080.
- Half store at 0x202, data 0x0000ABCD -> `oMemBE`=1100, `oMemData`=0xABCD0000. Half load at 0x201 -> `oFault`=01 after 1 cycle, no strobe.
- Word load with `iRdy` held low for 5 cycles -> strobe and address stable for all 6 ACCESS cycles, `oDone` 7 cycles after accept, `iReq` pulses during that time ignored.
- With `MEM_TIMEOUT_EN` and `TIMEOUT`=8, `iRdy` never asserted -> strobe drops after 8 ACCESS cycles, `oFault`=10. Then a fresh request completes normally.
- `nRst` pulsed low during ACCESS -> all outputs 0 immediately, no `oDone`. After release, the unit accepts a new request.
